// File: rtl/btb_assoc.sv
// Set-associative branch target buffer: combinational lookup, registered update,
// 2-bit direction counters and a one-set-per-cycle invalidate walk.
module btb_assoc #(
  parameter int         INDEX_SIZE = 6,
  parameter int         WAYS       = 2,
  parameter int         TAG_SIZE   = 30 - INDEX_SIZE,
  parameter logic [1:0] CTR_INIT   = 2'b10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pcF,
  output logic        BTBHit,
  output logic        predTakenF,
  output logic [31:0] branchimmF,
  input  logic        updValidD,
  input  logic [31:0] pcD,
  input  logic        takenD,
  input  logic [31:0] branchimmD,
  input  logic        flushReq,
  output logic        flushBusy
);

  localparam int SETS = 1 << INDEX_SIZE;
  localparam int WW   = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic {IDLE, WALK} state_t;

  if (TAG_SIZE + INDEX_SIZE != 30) begin : g_bad_tag
    $error("btb_assoc: TAG_SIZE + INDEX_SIZE must equal 30");
  end
  if (!(WAYS == 1 || WAYS == 2 || WAYS == 4)) begin : g_bad_ways
    $error("btb_assoc: WAYS must be 1, 2 or 4");
  end

  // Valid bits and victim pointers are flat vectors so reset and set-clear are single writes.
  logic [SETS*WAYS-1:0] valid_q;
  logic [SETS*WW-1:0]   vic_q;
  logic [TAG_SIZE-1:0]  tag_q [SETS][WAYS];
  logic [31:0]          tgt_q [SETS][WAYS];
  logic [1:0]           ctr_q [SETS][WAYS];

  state_t                state_q, state_nxt;
  logic [INDEX_SIZE-1:0] fcnt;

  logic [INDEX_SIZE-1:0] f_idx, u_idx;
  logic [TAG_SIZE-1:0]   f_tag, u_tag;
  logic [WAYS-1:0]       f_valid, u_valid;
  logic [WW-1:0]         u_vic, u_vic_nxt;
  logic                  f_hit, u_hit, u_free, upd_en;
  logic [WW-1:0]         f_way, u_way, u_free_way, u_alloc;
  logic [2:0]            f_nmatch;
  logic [1:0]            u_ctr, u_ctr_nxt;
  logic                  unused_lsbs;

  assign unused_lsbs = ^{pcF[1:0], pcD[1:0]};

  assign f_idx   = pcF[INDEX_SIZE+1:2];
  assign f_tag   = pcF[TAG_SIZE+INDEX_SIZE+1:INDEX_SIZE+2];
  assign u_idx   = pcD[INDEX_SIZE+1:2];
  assign u_tag   = pcD[TAG_SIZE+INDEX_SIZE+1:INDEX_SIZE+2];
  assign f_valid = valid_q[f_idx*WAYS +: WAYS];
  assign u_valid = valid_q[u_idx*WAYS +: WAYS];
  assign u_vic   = vic_q[u_idx*WW +: WW];

  // Descending scans so the lowest-numbered way is the one left selected.
  always_comb begin
    f_hit      = 1'b0;
    f_way      = '0;
    f_nmatch   = '0;
    u_hit      = 1'b0;
    u_way      = '0;
    u_free     = 1'b0;
    u_free_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (f_valid[w] && tag_q[f_idx][w] == f_tag) begin
        f_hit    = 1'b1;
        f_way    = WW'(w);
        f_nmatch = f_nmatch + 3'd1;
      end
      if (u_valid[w] && tag_q[u_idx][w] == u_tag) begin
        u_hit = 1'b1;
        u_way = WW'(w);
      end
      if (!u_valid[w]) begin
        u_free     = 1'b1;
        u_free_way = WW'(w);
      end
    end
  end

  assign u_alloc   = u_free ? u_free_way : u_vic;
  assign u_vic_nxt = (WAYS == 1) ? '0 : u_vic + 1'b1;
  assign upd_en    = updValidD && !flushBusy;
  assign u_ctr     = ctr_q[u_idx][u_way];

  always_comb begin
    u_ctr_nxt = u_ctr;
    if (takenD && u_ctr != 2'b11) u_ctr_nxt = u_ctr + 2'd1;
    else if (!takenD && u_ctr != 2'b00) u_ctr_nxt = u_ctr - 2'd1;
  end

  assign BTBHit     = f_hit && !flushBusy;
  assign predTakenF = BTBHit && ctr_q[f_idx][f_way][1];
  assign branchimmF = BTBHit ? tgt_q[f_idx][f_way] : 32'd0;

  // Flush walk FSM: state register, next-state logic, output logic.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      fcnt    <= '0;
    end else begin
      state_q <= state_nxt;
      fcnt    <= (state_q == WALK) ? fcnt + 1'b1 : '0;
    end
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:    if (flushReq) state_nxt = WALK;
      WALK:    if (fcnt == {INDEX_SIZE{1'b1}}) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    flushBusy = (state_q == WALK);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      vic_q   <= '0;
    end else if (flushBusy) begin
      valid_q[fcnt*WAYS +: WAYS] <= '0;
      vic_q[fcnt*WW +: WW]       <= '0;
    end else if (upd_en && !u_hit && takenD) begin
      valid_q[u_idx*WAYS + u_alloc] <= 1'b1;
      if (!u_free) vic_q[u_idx*WW +: WW] <= u_vic_nxt;
    end
  end

  // Payload arrays carry no reset; the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (upd_en) begin
      if (u_hit) begin
        ctr_q[u_idx][u_way] <= u_ctr_nxt;
        if (takenD) tgt_q[u_idx][u_way] <= branchimmD;
      end else if (takenD) begin
        tag_q[u_idx][u_alloc] <= u_tag;
        tgt_q[u_idx][u_alloc] <= branchimmD;
        ctr_q[u_idx][u_alloc] <= CTR_INIT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (f_nmatch <= 3'd1)
        else $error("btb_assoc: multiple ways match pcF %h", pcF);
    end
  end

endmodule

// File: tb/tb_btb_assoc.sv
// Bench for btb_assoc: table-driven lookup/update vectors through a scoreboard,
// plus hand-written flush-walk and reset-during-walk sequences.
module tb_btb_assoc;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pcF, pcD, branchimmD, branchimmF;
  logic        updValidD, takenD, flushReq;
  logic        BTBHit, predTakenF, flushBusy;

  always #5 clk = ~clk;

  btb_assoc #(.INDEX_SIZE(6), .WAYS(2)) dut (
    .clk(clk), .reset(reset), .pcF(pcF), .BTBHit(BTBHit), .predTakenF(predTakenF),
    .branchimmF(branchimmF), .updValidD(updValidD), .pcD(pcD), .takenD(takenD),
    .branchimmD(branchimmD), .flushReq(flushReq), .flushBusy(flushBusy)
  );

  typedef struct {
    logic        upd;
    logic [31:0] pcd;
    logic        tk;
    logic [31:0] tgt;
    logic [31:0] pcf;
    logic        hit;
    logic        pred;
    logic [31:0] imm;
  } vec_t;

  typedef struct {
    int          id;
    logic        hit;
    logic        pred;
    logic [31:0] imm;
    logic        busy;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   vid   = 0;

  logic [31:0] fill_pc [4] = '{32'h100, 32'h104, 32'h1A0, 32'h1F0};

  task automatic add(input logic upd, input logic [31:0] pcd, input logic tk, input logic [31:0] tgt,
                     input logic [31:0] pcf, input logic hit, input logic pred, input logic [31:0] imm);
    vec_t v;
    v.upd = upd; v.pcd = pcd; v.tk = tk; v.tgt = tgt; v.pcf = pcf;
    v.hit = hit; v.pred = pred; v.imm = imm;
    tbl.push_back(v);
  endtask

  task automatic check1(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Drives one cycle of stimulus just after the edge and returns at the following negedge.
  task automatic cyc(input logic flush, input logic upd, input logic [31:0] pcd, input logic tk,
                     input logic [31:0] tgt, input logic [31:0] pcf);
    @(posedge clk);
    #1;
    flushReq = flush; updValidD = upd; pcD = pcd; takenD = tk; branchimmD = tgt; pcF = pcf;
    @(negedge clk);
  endtask

  task automatic step_vec(input vec_t v);
    exp_t e, g;
    e.id = vid; e.hit = v.hit; e.pred = v.pred; e.imm = v.imm; e.busy = 1'b0;
    sb.push_back(e);
    cyc(1'b0, v.upd, v.pcd, v.tk, v.tgt, v.pcf);
    g = sb.pop_front();
    n_cmp++;
    if (BTBHit !== g.hit || predTakenF !== g.pred || branchimmF !== g.imm || flushBusy !== g.busy) begin
      n_bad++;
      $display("FAIL vec%0d: got hit=%0d pred=%0d imm=%h busy=%0d want hit=%0d pred=%0d imm=%h busy=%0d",
               g.id, BTBHit, predTakenF, branchimmF, flushBusy, g.hit, g.pred, g.imm, g.busy);
    end
    vid++;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1; updValidD = 1'b0; flushReq = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic fill4();
    vec_t v;
    for (int i = 0; i < 4; i++) begin
      v = '{1'b1, fill_pc[i], 1'b1, 32'hF0 + i, fill_pc[i], 1'b0, 1'b0, 32'h0};
      step_vec(v);
    end
    for (int i = 0; i < 4; i++) begin
      v = '{1'b0, 32'h0, 1'b0, 32'h0, fill_pc[i], 1'b1, 1'b1, 32'hF0 + i};
      step_vec(v);
    end
  endtask

  int busy_cnt, leak, split;
  bit done;

  initial begin
    reset = 1'b1; updValidD = 1'b0; flushReq = 1'b0; takenD = 1'b0;
    pcF = 32'h0; pcD = 32'h0; branchimmD = 32'h0;

    // Counter saturation, target update on taken only, write-after-read
    add(0, 32'h0,   0, 32'h0,   32'h100, 0, 0, 32'h0);
    add(1, 32'h100, 1, 32'h40,  32'h100, 0, 0, 32'h0);
    add(1, 32'h100, 1, 32'h40,  32'h100, 1, 1, 32'h40);
    add(1, 32'h100, 1, 32'h40,  32'h100, 1, 1, 32'h40);
    add(1, 32'h100, 0, 32'h999, 32'h100, 1, 1, 32'h40);
    add(1, 32'h100, 0, 32'h999, 32'h100, 1, 1, 32'h40);
    add(1, 32'h100, 0, 32'h999, 32'h100, 1, 0, 32'h40);
    add(1, 32'h100, 0, 32'h999, 32'h100, 1, 0, 32'h40);
    add(1, 32'h100, 1, 32'h80,  32'h100, 1, 0, 32'h40);
    add(1, 32'h100, 1, 32'h80,  32'h100, 1, 0, 32'h80);
    add(0, 32'h0,   0, 32'h0,   32'h102, 1, 1, 32'h80);
    add(1, 32'h200, 0, 32'h20,  32'h200, 0, 0, 32'h0);
    add(0, 32'h0,   0, 32'h0,   32'h200, 0, 0, 32'h0);
    add(1, 32'h300, 1, 32'h3C,  32'h300, 0, 0, 32'h0);
    add(0, 32'h0,   0, 32'h0,   32'h300, 1, 1, 32'h3C);
    split = tbl.size();
    // Same-set conflict: third allocation evicts way 0, fourth evicts way 1
    add(1, 32'h100,  1, 32'hA0, 32'h100,  0, 0, 32'h0);
    add(1, 32'h1100, 1, 32'hA1, 32'h100,  1, 1, 32'hA0);
    add(1, 32'h2100, 1, 32'hA2, 32'h1100, 1, 1, 32'hA1);
    add(0, 32'h0,    0, 32'h0,  32'h100,  0, 0, 32'h0);
    add(0, 32'h0,    0, 32'h0,  32'h1100, 1, 1, 32'hA1);
    add(0, 32'h0,    0, 32'h0,  32'h2100, 1, 1, 32'hA2);
    add(1, 32'h3100, 1, 32'hA3, 32'h2100, 1, 1, 32'hA2);
    add(0, 32'h0,    0, 32'h0,  32'h1100, 0, 0, 32'h0);
    add(0, 32'h0,    0, 32'h0,  32'h2100, 1, 1, 32'hA2);
    add(0, 32'h0,    0, 32'h0,  32'h3103, 1, 1, 32'hA3);

    do_reset();
    foreach (tbl[i]) begin
      if (i == split) do_reset();
      step_vec(tbl[i]);
    end

    // Full flush walk with an update at its start, one mid-walk, and a stray flushReq
    do_reset();
    fill4();
    cyc(1'b1, 1'b1, 32'h600, 1'b1, 32'h66, 32'h104);
    check1("flush_req_cycle_busy", 32'(flushBusy), 32'h0);
    check1("flush_req_cycle_hit", 32'(BTBHit), 32'h1);
    busy_cnt = 0; leak = 0; done = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      cyc(c == 20, c == 5, 32'h500, 1'b1, 32'h55, fill_pc[c % 4]);
      if (flushBusy) begin
        busy_cnt++;
        if (BTBHit || predTakenF || branchimmF != 32'h0) leak++;
      end else begin
        done = 1;
      end
    end
    check1("walk_busy_cycles", busy_cnt, 64);
    check1("walk_hit_leak", leak, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, fill_pc[i]);
      check1($sformatf("post_walk_miss_%0d", i), {BTBHit, predTakenF, branchimmF[29:0]}, 32'h0);
    end
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h500);
    check1("dropped_update_miss", 32'(BTBHit), 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h600);
    check1("same_cycle_update_flushed", 32'(BTBHit), 32'h0);

    // Reset at walk cycle 10 clears sets the walk had not yet reached
    do_reset();
    fill4();
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h1F0);
    busy_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h1F0);
      if (flushBusy) busy_cnt++;
    end
    check1("pre_reset_busy_cycles", busy_cnt, 10);
    do_reset();
    @(negedge clk);
    check1("reset_in_walk_busy", 32'(flushBusy), 32'h0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, fill_pc[i]);
      check1($sformatf("reset_in_walk_miss_%0d", i), {BTBHit, predTakenF, branchimmF[29:0]}, 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
